// File: rtl/matrix_b_loader.sv
// Packs a stream of ELEM_W-bit elements into a column-major 2x2 matrix word
// and hands the completed word to the multiplier over a valid/ready handshake.
module matrix_b_loader #(
  parameter int unsigned ELEM_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_W-1:0]     in_elem,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*ELEM_W-1:0]   matrix_b,
  output logic [1:0]            elem_count
);

  localparam int unsigned WORD_W = 4 * ELEM_W;
  localparam int unsigned NSLOT  = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          count_d;
  logic [WORD_W-1:0]   word_d;
  logic                in_ready_d;
  logic                out_valid_d;
  logic [1:0]          slot;
  logic                xfer;

  // Element k lands in slot {k[0], k[1]} so the selector reads it back by the same index.
  assign slot = {elem_count[0], elem_count[1]};
  assign xfer = in_valid && in_ready;

  // State, counter, word and handshake outputs all live in this one register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      elem_count <= 2'd0;
      matrix_b   <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_count <= count_d;
      matrix_b   <= word_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
    end
  end

  // Next-state, slot write and next handshake outputs.
  always_comb begin
    state_d     = state_q;
    count_d     = elem_count;
    word_d      = matrix_b;
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;

    unique case (state_q)
      FILL: begin
        if (abort) begin
          count_d = 2'd0;
        end else if (xfer) begin
          for (int unsigned s = 0; s < NSLOT; s++) begin
            if (slot == 2'(s)) begin
              word_d[s*ELEM_W +: ELEM_W] = in_elem;
            end
          end
          count_d = elem_count + 2'd1;
          if (elem_count == 2'd3) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A completed matrix is never discarded; only the output handshake leaves HOLD.
        if (out_valid && out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == HOLD);
  end

endmodule

// File: tb/tb_matrix_b_loader.sv
// Directed and randomized checks of matrix_b_loader against an element-index
// reference model that assembles the column-major word from the accepted elements.
module tb_matrix_b_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_elem;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] matrix_b;
  logic [1:0]  elem_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: elements by arrival index, fill count, completed flag.
  logic [3:0] m_elem [4];
  int         m_cnt;
  bit         m_hold;

  matrix_b_loader #(.ELEM_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_elem    (in_elem),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .matrix_b   (matrix_b),
    .elem_count (elem_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column-major 2x2: b00=e0, b10=e1, b01=e2, b11=e3; word = {b11, b10, b01, b00}.
  function automatic logic [15:0] model_word();
    return {m_elem[3], m_elem[1], m_elem[2], m_elem[0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, compare.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_elem[i] = 4'h0;
      m_cnt  = 0;
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (abort) begin
        m_cnt = 0;
      end else if (in_valid) begin
        m_elem[m_cnt] = in_elem;
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt  = 0;
          m_hold = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
    #1;
    check("out_valid",  16'(out_valid),  16'(m_hold));
    check("in_ready",   16'(in_ready),   16'(!m_hold));
    check("elem_count", 16'(elem_count), 16'(m_cnt));
    check("matrix_b",   matrix_b,        model_word());
  endtask

  task automatic send(input logic [3:0] v);
    in_valid = 1'b1;
    in_elem  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_elem = 4'h0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_elem[i] = 4'h0;
    m_cnt = 0; m_hold = 1'b0;
    tick(); tick();
    check("reset_matrix", matrix_b, 16'h0000);
    check("reset_ready", 16'(in_ready), 16'h1);
    rst_n = 1'b1;
    tick();

    // Back-to-back fill, then hold with no consumer.
    send(4'h1); send(4'h2); send(4'h3);
    check("pre_last_valid", 16'(out_valid), 16'h0);
    send(4'h4);
    check("fill1_word", matrix_b, 16'h4231);
    check("fill1_valid", 16'(out_valid), 16'h1);
    for (int i = 0; i < 10; i++) tick();
    check("hold_word", matrix_b, 16'h4231);

    // One-cycle consumer handshake, then second matrix.
    release_out();
    check("after_hs_valid", 16'(out_valid), 16'h0);
    check("after_hs_ready", 16'(in_ready), 16'h1);
    send(4'hA); send(4'hB); send(4'hC); send(4'hD);
    check("fill2_word", matrix_b, 16'hDBCA);
    release_out();

    // Gapped input; garbage while in_valid is low.
    for (int i = 0; i < 4; i++) begin
      send(4'(5 + i));
      in_elem = 4'hF;
      tick();
    end
    check("gapped_word", matrix_b, 16'h8675);
    release_out();

    // Abort beats a simultaneous transfer.
    send(4'hF); send(4'hE);
    abort = 1'b1; in_valid = 1'b1; in_elem = 4'h9;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_count", 16'(elem_count), 16'h0);
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    check("post_abort_word", matrix_b, 16'h4231);

    // Abort and in_valid during HOLD are ignored.
    abort = 1'b1; in_valid = 1'b1; in_elem = 4'h7;
    for (int i = 0; i < 3; i++) tick();
    abort = 1'b0; in_valid = 1'b0;
    check("hold_abort_valid", 16'(out_valid), 16'h1);
    check("hold_abort_word", matrix_b, 16'h4231);

    // Reset during HOLD, then mid-fill.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rst_hold_word", matrix_b, 16'h0000);
    check("rst_hold_ready", 16'(in_ready), 16'h1);
    send(4'h6); send(4'h3);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rst_fill_count", 16'(elem_count), 16'h0);
    check("rst_fill_word", matrix_b, 16'h0000);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_elem   = 4'($urandom);
      abort     = 1'($urandom_range(0, 15) == 0);
      out_ready = 1'($urandom_range(0, 2) == 0);
      rst_n     = 1'($urandom_range(0, 63) != 0);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
